rgb_wheel_pwm: RTL and testbench

Parametrised RGB colour-wheel PWM engine driving the on-board RGB LED pins.
- Generalises the fixed six-phase hue cycler: configurable duty resolution, hue step rate and output polarity.
- Adds runtime brightness scaling, four operating modes, a hue resynchronisation input and status outputs.
- Sits directly below the board top level; its three outputs connect straight to the LED pins.

---
 rtl/rgb_wheel_pwm.sv | 154 +++++++++++++++
 tb/tb_rgb_wheel_pwm.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_wheel_pwm.sv
// RGB colour-wheel PWM engine: six-phase hue ramp, brightness scaling and
// per-frame latched duties driving three polarity-configurable LED pins.
module rgb_wheel_pwm #(
    parameter int PWM_BITS        = 8,
    parameter int FRAMES_PER_STEP = 4,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              mode,
    input  logic [PWM_BITS-1:0]     brightness,
    input  logic [3*PWM_BITS-1:0]   static_rgb,
    input  logic                    hue_sync,
    output logic                    rgb_r,
    output logic                    rgb_g,
    output logic                    rgb_b,
    output logic                    frame_start,
    output logic [2:0]              phase,
    output logic [PWM_BITS-1:0]     ramp
);

    localparam int B  = PWM_BITS;
    localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [B-1:0]  MAX   = '1;
    localparam logic [FW-1:0] FLAST = FW'(FRAMES_PER_STEP - 1);

    typedef enum logic [1:0] {MODE_OFF, MODE_WHEEL, MODE_HOLD, MODE_STATIC} mode_e;
    typedef enum logic [2:0] {PH0, PH1, PH2, PH3, PH4, PH5} phase_e;

    logic [B-1:0]  pwmCnt_q, pwmCnt_d;
    logic [FW-1:0] frameCnt_q, frameCnt_d;
    phase_e        phase_q, phase_d;
    logic [B-1:0]  ramp_q, ramp_d;
    logic [B-1:0]  dutyR_q, dutyG_q, dutyB_q;
    logic [B-1:0]  dutyR_d, dutyG_d, dutyB_d;
    logic          frameStart_q;

    mode_e        modeSel;
    logic         pwmWrap;
    logic         stepTick;
    logic [B-1:0] vr, vg, vb;
    logic [B-1:0] srcR, srcG, srcB;
    logic [B:0]   scaleK;

    // Truncated (v * k) >> B; k = brightness+1 so full brightness is exact.
    function automatic logic [B-1:0] scale(input logic [B-1:0] v, input logic [B:0] k);
        logic [2*B:0] p;
        p = {{(B+1){1'b0}}, v} * {{B{1'b0}}, k};
        return p[2*B-1:B];
    endfunction

    assign modeSel  = mode_e'(mode);
    assign pwmWrap  = (pwmCnt_q == MAX);
    assign stepTick = pwmWrap && (frameCnt_q == FLAST);
    assign scaleK   = {1'b0, brightness} + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwmCnt_q     <= '0;
            frameCnt_q   <= '0;
            phase_q      <= PH0;
            ramp_q       <= '0;
            dutyR_q      <= '0;
            dutyG_q      <= '0;
            dutyB_q      <= '0;
            frameStart_q <= 1'b0;
        end else begin
            pwmCnt_q     <= pwmCnt_d;
            frameCnt_q   <= frameCnt_d;
            phase_q      <= phase_d;
            ramp_q       <= ramp_d;
            dutyR_q      <= dutyR_d;
            dutyG_q      <= dutyG_d;
            dutyB_q      <= dutyB_d;
            frameStart_q <= pwmWrap;
        end
    end

    always_comb begin
        pwmCnt_d   = pwmCnt_q + 1'b1;
        frameCnt_d = frameCnt_q;
        if (pwmWrap) begin
            frameCnt_d = (frameCnt_q == FLAST) ? '0 : frameCnt_q + 1'b1;
        end
    end

    // Hue FSM: sync wins over a coincident step; only WHEEL advances.
    always_comb begin
        phase_d = phase_q;
        ramp_d  = ramp_q;
        if (hue_sync) begin
            phase_d = PH0;
            ramp_d  = '0;
        end else if (stepTick && (modeSel == MODE_WHEEL)) begin
            if (ramp_q == MAX) begin
                ramp_d = '0;
                case (phase_q)
                    PH0:     phase_d = PH1;
                    PH1:     phase_d = PH2;
                    PH2:     phase_d = PH3;
                    PH3:     phase_d = PH4;
                    PH4:     phase_d = PH5;
                    default: phase_d = PH0;
                endcase
            end else begin
                ramp_d = ramp_q + 1'b1;
            end
        end
    end

    always_comb begin
        vr = '0;
        vg = '0;
        vb = '0;
        case (phase_q)
            PH0: begin vr = MAX;          vg = ramp_q;       vb = '0;           end
            PH1: begin vr = MAX - ramp_q; vg = MAX;          vb = '0;           end
            PH2: begin vr = '0;           vg = MAX;          vb = ramp_q;       end
            PH3: begin vr = '0;           vg = MAX - ramp_q; vb = MAX;          end
            PH4: begin vr = ramp_q;       vg = '0;           vb = MAX;          end
            PH5: begin vr = MAX;          vg = '0;           vb = MAX - ramp_q; end
            default: ;
        endcase
    end

    // Duties latch only at frame end so input changes never split a frame.
    always_comb begin
        srcR    = (modeSel == MODE_STATIC) ? static_rgb[3*B-1:2*B] : vr;
        srcG    = (modeSel == MODE_STATIC) ? static_rgb[2*B-1:B]   : vg;
        srcB    = (modeSel == MODE_STATIC) ? static_rgb[B-1:0]     : vb;
        dutyR_d = dutyR_q;
        dutyG_d = dutyG_q;
        dutyB_d = dutyB_q;
        if (pwmWrap) begin
            if (modeSel == MODE_OFF) begin
                dutyR_d = '0;
                dutyG_d = '0;
                dutyB_d = '0;
            end else begin
                dutyR_d = scale(srcR, scaleK);
                dutyG_d = scale(srcG, scaleK);
                dutyB_d = scale(srcB, scaleK);
            end
        end
    end

    assign rgb_r       = (pwmCnt_q < dutyR_q) ^ ACTIVE_LOW;
    assign rgb_g       = (pwmCnt_q < dutyG_q) ^ ACTIVE_LOW;
    assign rgb_b       = (pwmCnt_q < dutyB_q) ^ ACTIVE_LOW;
    assign frame_start = frameStart_q;
    assign phase       = phase_q;
    assign ramp        = ramp_q;

endmodule

// File: tb/tb_rgb_wheel_pwm.sv
// Directed self-checking bench for rgb_wheel_pwm with B=4, one frame per
// hue step and active-low pins; frames are counted from reset release.
module tb_rgb_wheel_pwm;

    logic        clk;
    logic        rst_n;
    logic [1:0]  mode;
    logic [3:0]  brightness;
    logic [11:0] static_rgb;
    logic        hue_sync;
    logic        rgb_r, rgb_g, rgb_b;
    logic        frame_start;
    logic [2:0]  phase;
    logic [3:0]  ramp;

    int checks = 0;
    int fails  = 0;
    int nr, ng, nb, nfs;

    rgb_wheel_pwm #(
        .PWM_BITS(4),
        .FRAMES_PER_STEP(1),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .mode(mode),
        .brightness(brightness),
        .static_rgb(static_rgb),
        .hue_sync(hue_sync),
        .rgb_r(rgb_r),
        .rgb_g(rgb_g),
        .rgb_b(rgb_b),
        .frame_start(frame_start),
        .phase(phase),
        .ramp(ramp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic waitFrames(input int n);
        repeat (n * 16) @(negedge clk);
    endtask

    // Starts on a frame_start negedge; counts active-low cycles over 16 clocks.
    task automatic measureFrame(output int cr, output int cg, output int cb, output int cf);
        cr = 0; cg = 0; cb = 0; cf = 0;
        for (int i = 0; i < 16; i++) begin
            if (rgb_r == 1'b0) cr++;
            if (rgb_g == 1'b0) cg++;
            if (rgb_b == 1'b0) cb++;
            if (frame_start == 1'b1) cf++;
            @(negedge clk);
        end
    endtask

    task automatic checkHue(input string name, input logic [2:0] ePh, input logic [3:0] eRamp);
        checks++;
        if (phase !== ePh || ramp !== eRamp) begin
            fails++;
            $display("[TB] FAIL %s: phase/ramp got %0d/%0d expected %0d/%0d", name, phase, ramp, ePh, eRamp);
        end
    endtask

    task automatic checkCounts(input string name, input int er, input int eg, input int eb);
        checks++;
        if (nr != er || ng != eg || nb != eb) begin
            fails++;
            $display("[TB] FAIL %s: on-cycles r/g/b got %0d/%0d/%0d expected %0d/%0d/%0d",
                     name, nr, ng, nb, er, eg, eb);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode = 2'd1; brightness = 4'd15; static_rgb = '0; hue_sync = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rgb_r, rgb_g, rgb_b} !== 3'b111) begin
            fails++;
            $display("[TB] FAIL reset_pins: got %b expected 111", {rgb_r, rgb_g, rgb_b});
        end
        checkHue("reset_hue", 3'd0, 4'd0);
        checks++;
        if (frame_start !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_frame_start: got %b expected 0", frame_start);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (frame_start !== 1'b0) begin
            fails++;
            $display("[TB] FAIL release_frame_start: got %b expected 0", frame_start);
        end
    endtask

    task automatic test_wheel();
        bit found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (frame_start === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!found) begin
            fails++;
            $display("[TB] FAIL first_frame_start: got none expected pulse within 64 clocks");
        end
        checkHue("wheel_frame1_hue", 3'd0, 4'd1);
        measureFrame(nr, ng, nb, nfs);
        checkCounts("wheel_frame1", 15, 0, 0);
        checks++;
        if (nfs != 1) begin
            fails++;
            $display("[TB] FAIL frame_start_count: got %0d expected 1", nfs);
        end
        waitFrames(14);
        checkHue("wheel_16_steps", 3'd1, 4'd0);
        measureFrame(nr, ng, nb, nfs);
        checkCounts("wheel_frame16", 15, 15, 0);
        waitFrames(7);
        measureFrame(nr, ng, nb, nfs);
        checkCounts("wheel_frame24", 8, 15, 0);
        waitFrames(71);
        checkHue("wheel_96_steps", 3'd0, 4'd0);
    endtask

    task automatic test_brightness();
        brightness = 4'd7;
        measureFrame(nr, ng, nb, nfs);
        checkCounts("bright_midframe_nochange", 15, 0, 0);
        measureFrame(nr, ng, nb, nfs);
        checkCounts("bright_7", 7, 0, 0);
        brightness = 4'd0;
        waitFrames(1);
        measureFrame(nr, ng, nb, nfs);
        checkCounts("bright_0", 0, 0, 0);
    endtask

    task automatic test_static();
        mode = 2'd3; static_rgb = {4'd3, 4'd0, 4'd15}; brightness = 4'd15;
        waitFrames(1);
        measureFrame(nr, ng, nb, nfs);
        checkCounts("static_3_0_15", 3, 0, 15);
        nr = 0; ng = 0; nb = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 5) static_rgb = {4'd15, 4'd15, 4'd0};
            if (rgb_r == 1'b0) nr++;
            if (rgb_g == 1'b0) ng++;
            if (rgb_b == 1'b0) nb++;
            @(negedge clk);
        end
        checkCounts("static_midframe_change", 3, 0, 15);
        measureFrame(nr, ng, nb, nfs);
        checkCounts("static_next_frame", 15, 15, 0);
        checkHue("static_frozen", 3'd0, 4'd4);
    endtask

    task automatic test_hold();
        mode = 2'd2;
        waitFrames(10);
        checkHue("hold_frozen", 3'd0, 4'd4);
        measureFrame(nr, ng, nb, nfs);
        checkCounts("hold_colour", 15, 4, 0);
    endtask

    task automatic test_hue_sync();
        mode = 2'd1;
        repeat (15) @(negedge clk);
        hue_sync = 1'b1;
        @(negedge clk);
        hue_sync = 1'b0;
        checkHue("sync_over_step", 3'd0, 4'd0);
        measureFrame(nr, ng, nb, nfs);
        checkCounts("sync_duty_pre_update", 15, 4, 0);
        checkHue("wheel_after_sync", 3'd0, 4'd1);
    endtask

    task automatic test_off();
        mode = 2'd0;
        waitFrames(1);
        measureFrame(nr, ng, nb, nfs);
        checkCounts("off_pins", 0, 0, 0);
        waitFrames(3);
        checkHue("off_frozen", 3'd0, 4'd1);
        mode = 2'd1;
        waitFrames(1);
        checkHue("off_resume", 3'd0, 4'd2);
        measureFrame(nr, ng, nb, nfs);
        checkCounts("off_resume_colour", 15, 1, 0);
    endtask

    task automatic test_async_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (rgb_r !== 1'b0) begin
            fails++;
            $display("[TB] FAIL pre_reset_red_active: got %b expected 0", rgb_r);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rgb_r, rgb_g, rgb_b} !== 3'b111) begin
            fails++;
            $display("[TB] FAIL async_reset_pins: got %b expected 111", {rgb_r, rgb_g, rgb_b});
        end
        checkHue("async_reset_hue", 3'd0, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_wheel();
        test_brightness();
        test_static();
        test_hold();
        test_hue_sync();
        test_off();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
